// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and helpers for the clock display back-end.
package seg_scan_driver_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] EN_OFF    = 4'b1111;

  typedef enum logic {
    PAGE_HHMM = 1'b0,
    PAGE_MMSS = 1'b1
  } page_e;

  // Digit positions, 0 = rightmost
  localparam logic [1:0] DIG_0 = 2'd0;
  localparam logic [1:0] DIG_1 = 2'd1;
  localparam logic [1:0] DIG_2 = 2'd2;
  localparam logic [1:0] DIG_3 = 2'd3;

  // Four BCD digits, index 3 = leftmost
  typedef logic [3:0][3:0] digits_t;

  // Pick the four displayed digits for the selected page
  function automatic digits_t page_sel(input logic pg,
                                       input logic [3:0] ht, hu, mt, mu, st, su);
    return (pg == PAGE_MMSS) ? {mt, mu, st, su} : {ht, hu, mt, mu};
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Time digits and display controls in, multiplexed display lines out.
interface seg_scan_driver_if;
  logic [3:0] hr_t, hr_u, min_t, min_u, sec_t, sec_u;
  logic       page;
  logic       lzb;
  logic       dp_on;
  logic [3:0] blink_mask;
  logic [6:0] seg;
  logic [3:0] en;
  logic       dp;

  // Clock core side: supplies digits/controls, observes the display lines
  modport master (
    output hr_t, hr_u, min_t, min_u, sec_t, sec_u, page, lzb, dp_on, blink_mask,
    input  seg, en, dp
  );

  // Display driver side
  modport slave (
    input  hr_t, hr_u, min_t, min_u, sec_t, sec_u, page, lzb, dp_on, blink_mask,
    output seg, en, dp
  );
endinterface

// File: rtl/seg_scan_driver_hex7seg.sv
// Hex digit to active-low 7-segment pattern {a,b,c,d,e,f,g}.
module seg_scan_driver_hex7seg (
  input  logic [3:0] val,
  output logic [6:0] seg
);

  // Full hex glyph set; codes above 9 show A..F rather than an error mark
  always_comb begin
    seg = 7'b1111111;
    unique case (val)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'ha: seg = 7'b0001000;
      4'hb: seg = 7'b1100000;
      4'hc: seg = 7'b0110001;
      4'hd: seg = 7'b1000010;
      4'he: seg = 7'b0110000;
      4'hf: seg = 7'b0111000;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Scans four of the six time digits onto a common-anode 4-digit display,
// with page select, leading-zero blanking, separator dot and digit blink.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 128
) (
  input  logic clk,
  input  logic clr,
  seg_scan_driver_if.slave bus
);

  localparam int PW = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] pre;
  logic          tick;
  logic [1:0]    idx, idx_nx;
  logic          fbnd;
  digits_t       live, snap;
  logic          snap_lzb;
  logic          run;
  logic [FW-1:0] fc;
  logic          phase, wrap, ph_eff;
  logic [3:0]    cur_val;
  logic [6:0]    hex_seg, seg_nx, seg_q;
  logic [3:0]    en_nx, en_q;
  logic          dp_nx, dp_q, blinked, lz_blank;

  assign tick   = (pre == PW'(SCAN_DIV - 1));
  assign idx_nx = idx + 2'd1;
  assign fbnd   = tick && (idx == DIG_3);
  assign live   = page_sel(bus.page, bus.hr_t, bus.hr_u, bus.min_t, bus.min_u,
                           bus.sec_t, bus.sec_u);

  // The first boundary after reset only opens frame 0; later ones close a frame
  assign wrap   = fbnd && run && (fc == FW'(BLINK_FRAMES - 1));
  // Phase that applies to the slot being loaded, so a new phase covers all of its frame
  assign ph_eff = phase ^ wrap;

  // Slot-rate prescaler
  always_ff @(posedge clk or posedge clr) begin
    if (clr)       pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 1'b1;
  end

  // Digit index; reset to 3 so the first tick is a frame boundary
  always_ff @(posedge clk or posedge clr) begin
    if (clr)       idx <= DIG_3;
    else if (tick) idx <= idx_nx;
  end

  // Frame snapshot of the page-selected digits and blank enable
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      snap     <= '0;
      snap_lzb <= 1'b0;
    end else if (fbnd) begin
      snap     <= live;
      snap_lzb <= bus.lzb;
    end
  end

  // Frame counter and blink phase
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      run   <= 1'b0;
      fc    <= '0;
      phase <= 1'b0;
    end else if (fbnd) begin
      run <= 1'b1;
      if (wrap) begin
        fc    <= '0;
        phase <= ~phase;
      end else if (run) begin
        fc <= fc + 1'b1;
      end
    end
  end

  // Digit 0 is loaded on the latching edge itself, so it bypasses the snapshot
  always_comb begin
    cur_val = snap[idx_nx];
    if (fbnd) cur_val = live[DIG_0];
  end

  seg_scan_driver_hex7seg u_hex (
    .val (cur_val),
    .seg (hex_seg)
  );

  // Next display values for the slot being entered
  always_comb begin
    blinked  = ph_eff && bus.blink_mask[idx_nx];
    lz_blank = (idx_nx == DIG_3) && snap_lzb && (snap[DIG_3] == 4'd0);
    seg_nx   = hex_seg;
    if (blinked || lz_blank) seg_nx = SEG_BLANK;
    en_nx    = ~(4'b0001 << idx_nx);
    dp_nx    = ~((idx_nx == DIG_2) && bus.dp_on && !blinked);
  end

  // Registered display lines, changing only at slot boundaries
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      seg_q <= SEG_BLANK;
      en_q  <= EN_OFF;
      dp_q  <= 1'b1;
    end else if (tick) begin
      seg_q <= seg_nx;
      en_q  <= en_nx;
      dp_q  <= dp_nx;
    end
  end

  assign bus.seg = seg_q;
  assign bus.en  = en_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: slot-by-slot comparison against a frame-level model.
module tb_seg_scan_driver;

  localparam int SD = 4;
  localparam int BF = 2;

  logic clk = 1'b0;
  logic clr;
  int   checks = 0;
  int   errors = 0;
  int   k;          // ticks since reset release
  int   snap [4];   // model snapshot, index 3 = leftmost
  bit   slzb;

  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  seg_scan_driver_if bus ();

  seg_scan_driver #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_seg"}, bus.seg, 7'h7F);
    chk({tag, "_en"}, {3'b0, bus.en}, 7'h0F);
    chk({tag, "_dp"}, {6'b0, bus.dp}, 7'h01);
  endtask

  // Model: tick k shows digit k%4 of frame k/4; frame latched at its first tick;
  // frames blink in alternating groups of BF frames starting with a visible group.
  task automatic expect_slot();
    int d, f;
    bit bl;
    logic [6:0] es;
    logic [3:0] een;
    logic       edp;
    d = k % 4;
    f = k / 4;
    if (d == 0) begin
      if (bus.page) begin
        snap[3] = bus.min_t; snap[2] = bus.min_u; snap[1] = bus.sec_t; snap[0] = bus.sec_u;
      end else begin
        snap[3] = bus.hr_t;  snap[2] = bus.hr_u;  snap[1] = bus.min_t; snap[0] = bus.min_u;
      end
      slzb = bus.lzb;
    end
    bl  = (((f / BF) % 2) == 1) && bus.blink_mask[d];
    een = 4'b1111;
    een[d] = 1'b0;
    es  = glyph[snap[d]];
    if (bl || (d == 3 && slzb && snap[3] == 0)) es = 7'h7F;
    edp = !(d == 2 && bus.dp_on && !bl);
    chk($sformatf("k%0d_en", k), {3'b0, bus.en}, {3'b0, een});
    chk($sformatf("k%0d_seg", k), bus.seg, es);
    chk($sformatf("k%0d_dp", k), {6'b0, bus.dp}, {6'b0, edp});
    k++;
  endtask

  task automatic slot();
    repeat (SD) @(posedge clk);
    #1;
    expect_slot();
  endtask

  // After clr falls: unchanged for SD-1 clocks, first slot on the SD-th clock
  task automatic restart(input string tag);
    k = 0;
    repeat (SD - 1) @(posedge clk);
    #1;
    chk_reset({tag, "_hold"});
    @(posedge clk);
    #1;
    expect_slot();
  endtask

  initial begin
    clr = 1'b1;
    bus.hr_t = 4'd1; bus.hr_u = 4'd2; bus.min_t = 4'd3; bus.min_u = 4'd4;
    bus.sec_t = 4'd5; bus.sec_u = 4'd6;
    bus.page = 1'b0; bus.lzb = 1'b0; bus.dp_on = 1'b0; bus.blink_mask = 4'b0000;
    k = 0;

    // Reset held with clock running
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");

    // Release and basic scan of HH.MM = 12.34
    @(negedge clk);
    clr = 1'b0;
    restart("rel");
    repeat (7) slot();

    // Mid-frame page/digit change takes effect only at the next frame
    slot();
    slot();
    bus.min_u = 4'd7;
    bus.page  = 1'b1;
    repeat (6) slot();

    // Leading-zero blank and separator dot
    bus.page = 1'b0; bus.hr_t = 4'd0; bus.lzb = 1'b1; bus.dp_on = 1'b1;
    repeat (8) slot();

    // Blink two right digits across several phase changes
    bus.blink_mask = 4'b0011;
    repeat (16) slot();

    // Random inputs, changed between ticks
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.hr_t  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        bus.min_t = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        bus.hr_u  = 4'($urandom_range(0, 15));
        bus.min_u = 4'($urandom_range(0, 15));
        bus.sec_t = 4'($urandom_range(0, 15));
        bus.sec_u = 4'($urandom_range(0, 15));
        bus.page  = 1'($urandom_range(0, 1));
        bus.lzb   = 1'($urandom_range(0, 1));
      end
      bus.dp_on      = 1'($urandom_range(0, 1));
      bus.blink_mask = 4'($urandom_range(0, 15));
      slot();
    end

    // Mid-frame clr during digit 2: immediate reset without a clock edge
    bus.blink_mask = 4'b1111;
    bus.dp_on = 1'b1;
    while (((k - 1) % 4) != 2) slot();
    #2;
    clr = 1'b1;
    #1;
    chk_reset("midclr");
    #3;
    clr = 1'b0;
    restart("rerel");
    repeat (15) slot();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
